// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: ISA opcodes, FSM states and
// the predicate that routes an opcode to the iterative multiply/divide unit.
package alu_pkg;

   localparam logic [4:0] OP_LDW  = 5'b00000;
   localparam logic [4:0] OP_LDWI = 5'b00001;
   localparam logic [4:0] OP_STW  = 5'b00010;
   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_SHR  = 5'b00101;
   localparam logic [4:0] OP_SHL  = 5'b00110;
   localparam logic [4:0] OP_ROR  = 5'b00111;
   localparam logic [4:0] OP_ROL  = 5'b01000;
   localparam logic [4:0] OP_AND  = 5'b01001;
   localparam logic [4:0] OP_OR   = 5'b01010;
   localparam logic [4:0] OP_ADDI = 5'b01011;
   localparam logic [4:0] OP_ANDI = 5'b01100;
   localparam logic [4:0] OP_ORI  = 5'b01101;
   localparam logic [4:0] OP_MUL  = 5'b01110;
   localparam logic [4:0] OP_DIV  = 5'b01111;
   localparam logic [4:0] OP_NEG  = 5'b10000;
   localparam logic [4:0] OP_NOT  = 5'b10001;
   localparam logic [4:0] OP_BR   = 5'b10010;
   localparam logic [4:0] OP_JR   = 5'b10011;
   localparam logic [4:0] OP_JAL  = 5'b10100;
   localparam logic [4:0] OP_IN   = 5'b10101;
   localparam logic [4:0] OP_OUT  = 5'b10110;
   localparam logic [4:0] OP_MFHI = 5'b10111;
   localparam logic [4:0] OP_MFLO = 5'b11000;
   localparam logic [4:0] OP_NOP  = 5'b11001;
   localparam logic [4:0] OP_HALT = 5'b11010;

   typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

   function automatic logic is_iterative(input logic [4:0] op);
      return (op == OP_MUL) || (op == OP_DIV);
   endfunction

endpackage

// File: rtl/seq_muldiv_unit.sv
// Iterative signed multiply (radix-2 shift-add) and divide (restoring) on
// operand magnitudes; signs are reapplied by the fix strobe.
module seq_muldiv_unit
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               clr,
   input  logic               load,
   input  logic               step,
   input  logic               fix,
   input  logic               is_div,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               last,
   output logic [2*WIDTH-1:0] res,
   output logic               dz
);

   localparam int CW = $clog2(WIDTH + 1);

   function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v);
      return v[WIDTH-1] ? $unsigned(-v) : $unsigned(v);
   endfunction

   function automatic logic [WIDTH-1:0] sign_w(input logic neg, input logic [WIDTH-1:0] v);
      return neg ? -v : v;
   endfunction

   function automatic logic [2*WIDTH-1:0] sign_2w(input logic neg, input logic [2*WIDTH-1:0] v);
      return neg ? -v : v;
   endfunction

   logic               is_div_r, neg_q_r, neg_a_r, zero_r, dz_r;
   logic [WIDTH-1:0]   mag_b_r, lo_r, lo_nxt, quo_fix;
   logic [WIDTH:0]     hi_r, hi_nxt, mul_sum, div_shift, div_trial;
   logic [CW-1:0]      cnt_r;
   logic [2*WIDTH-1:0] res_r, fixed;

   // hi holds the running partial product (mul) or partial remainder (div);
   // lo holds the multiplier being shifted out or the quotient shifted in.
   always_comb begin
      hi_nxt    = hi_r;
      lo_nxt    = lo_r;
      mul_sum   = {1'b0, hi_r[WIDTH-1:0]} + (lo_r[0] ? {1'b0, mag_b_r} : '0);
      div_shift = {hi_r[WIDTH-1:0], lo_r[WIDTH-1]};
      div_trial = div_shift - {1'b0, mag_b_r};
      if (is_div_r) begin
         if (!div_trial[WIDTH]) begin
            hi_nxt = div_trial;
            lo_nxt = {lo_r[WIDTH-2:0], 1'b1};
         end else begin
            hi_nxt = div_shift;
            lo_nxt = {lo_r[WIDTH-2:0], 1'b0};
         end
      end else begin
         hi_nxt = {1'b0, mul_sum[WIDTH:1]};
         lo_nxt = {mul_sum[0], lo_r[WIDTH-1:1]};
      end
   end

   // A zero divisor leaves the remainder equal to |RA|, so the sign fix restores RA in HI.
   always_comb begin
      quo_fix = zero_r ? {WIDTH{1'b1}} : sign_w(neg_q_r, lo_r);
      if (is_div_r)
         fixed = {sign_w(neg_a_r, hi_r[WIDTH-1:0]), quo_fix};
      else
         fixed = sign_2w(neg_q_r, {hi_r[WIDTH-1:0], lo_r});
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         cnt_r <= '0;
         res_r <= '0;
         dz_r  <= 1'b0;
      end else if (load) begin
         is_div_r <= is_div;
         neg_q_r  <= a[WIDTH-1] ^ b[WIDTH-1];
         neg_a_r  <= a[WIDTH-1];
         zero_r   <= is_div && (b == '0);
         mag_b_r  <= mag(b);
         hi_r     <= '0;
         lo_r     <= mag(a);
         cnt_r    <= CW'(WIDTH);
         dz_r     <= 1'b0;
      end else if (step) begin
         hi_r  <= hi_nxt;
         lo_r  <= lo_nxt;
         cnt_r <= cnt_r - 1'b1;
      end else if (fix) begin
         res_r <= fixed;
         dz_r  <= is_div_r & zero_r;
      end
   end

   assign last = (cnt_r == CW'(1));
   assign res  = res_r;
   assign dz   = dz_r;

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle ops finish one cycle after issue, multiply
// and divide iterate in seq_muldiv_unit under a start/done handshake.
module seq_alu
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic               clk,
   input  logic               clr,
   input  logic               start,
   input  logic [4:0]         opcode,
   input  logic [WIDTH-1:0]   RA,
   input  logic [WIDTH-1:0]   RB,
   input  logic [WIDTH-1:0]   RPC,
   input  logic               IncPC,
   input  logic               brn_flag,
   output logic [2*WIDTH-1:0] RC,
   output logic [WIDTH-1:0]   aluPC,
   output logic               busy,
   output logic               done,
   output logic               div_zero
);

   state_t state, state_nxt;

   logic                    sc_issue, md_load, md_step, md_fix, md_last, md_dz;
   logic                    use_md_r;
   logic [2*WIDTH-1:0]      md_res, rc_r, rot_l, rot_r;
   logic [WIDTH-1:0]        pc_r, pc_pend, pc_dflt, pc_sum, sc_lo, sc_pc;
   logic [SHW-1:0]          amt;
   logic signed [WIDTH-1:0] ra_s;

   seq_muldiv_unit #(.WIDTH(WIDTH)) u_muldiv (
      .clk    (clk),
      .clr    (clr),
      .load   (md_load),
      .step   (md_step),
      .fix    (md_fix),
      .is_div (opcode == OP_DIV),
      .a      (RA),
      .b      (RB),
      .last   (md_last),
      .res    (md_res),
      .dz     (md_dz)
   );

   assign ra_s    = RA;
   assign amt     = RB[SHW-1:0];
   assign pc_dflt = IncPC ? RPC + WIDTH'(1) : RPC;
   assign pc_sum  = RA + RB;

   always_comb begin
      sc_lo = '0;
      sc_pc = pc_dflt;
      rot_l = {RA, RA} << amt;
      rot_r = {RA, RA} >> amt;
      case (opcode)
         OP_LDW, OP_LDWI, OP_STW,
         OP_ADD, OP_ADDI:         sc_lo = RA + RB;
         OP_SUB:                  sc_lo = RA - RB;
         OP_AND, OP_ANDI:         sc_lo = RA & RB;
         OP_OR, OP_ORI:           sc_lo = RA | RB;
         OP_SHL:                  sc_lo = RA << amt;
         OP_SHR:                  sc_lo = RA >> amt;
         OP_ROL:                  sc_lo = rot_l[2*WIDTH-1:WIDTH];
         OP_ROR:                  sc_lo = rot_r[WIDTH-1:0];
         OP_NEG:                  sc_lo = $unsigned(-ra_s);
         OP_NOT:                  sc_lo = ~RB;
         OP_BR:                   if (brn_flag) sc_pc = pc_sum;
         OP_JR:                   sc_pc = pc_sum;
         OP_JAL: begin
            sc_pc = pc_sum;
            sc_lo = RPC + WIDTH'(1);
         end
         default: ;
      endcase
   end

   always_comb begin
      state_nxt = state;
      sc_issue  = 1'b0;
      md_load   = 1'b0;
      md_step   = 1'b0;
      md_fix    = 1'b0;
      busy      = (state != IDLE);
      done      = (state == DONE);
      case (state)
         IDLE: if (start) begin
            if (is_iterative(opcode)) begin
               md_load   = 1'b1;
               state_nxt = ITER;
            end else begin
               sc_issue  = 1'b1;
               state_nxt = DONE;
            end
         end
         ITER: begin
            md_step = 1'b1;
            if (md_last) state_nxt = FIX;
         end
         FIX: begin
            md_fix    = 1'b1;
            state_nxt = DONE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Results land in the output registers only on the edge that enters DONE.
   always_ff @(posedge clk) begin
      if (clr) begin
         state    <= IDLE;
         rc_r     <= '0;
         pc_r     <= '0;
         use_md_r <= 1'b0;
      end else begin
         state <= state_nxt;
         if (sc_issue) begin
            rc_r     <= {{WIDTH{1'b0}}, sc_lo};
            pc_r     <= sc_pc;
            use_md_r <= 1'b0;
         end
         if (md_load) pc_pend <= pc_dflt;
         if (md_fix) begin
            pc_r     <= pc_pend;
            use_md_r <= 1'b1;
         end
      end
   end

   assign RC       = use_md_r ? md_res : rc_r;
   assign aluPC    = pc_r;
   assign div_zero = use_md_r & md_dz;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu at WIDTH=32 with hand-computed expectations.
module tb_seq_alu;

   logic        clk = 1'b0;
   logic        clr, start, IncPC, brn_flag;
   logic [4:0]  opcode;
   logic [31:0] RA, RB, RPC, aluPC;
   logic [63:0] RC;
   logic        busy, done, div_zero;

   int checks = 0;
   int errors = 0;
   int lat, bcnt, dcnt;

   always #5 clk = ~clk;

   seq_alu #(.WIDTH(32)) dut (
      .clk      (clk),
      .clr      (clr),
      .start    (start),
      .opcode   (opcode),
      .RA       (RA),
      .RB       (RB),
      .RPC      (RPC),
      .IncPC    (IncPC),
      .brn_flag (brn_flag),
      .RC       (RC),
      .aluPC    (aluPC),
      .busy     (busy),
      .done     (done),
      .div_zero (div_zero)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Issue one op; count cycles to done (latency) and busy cycles seen.
   // A nonzero ignore_at pulses start with an add that many cycles after issue.
   task automatic run_op(input logic [4:0] op, input logic [31:0] ra, input logic [31:0] rb,
                         input logic [31:0] rpc, input logic inc, input logic brn,
                         input int ignore_at, output int l, output int b);
      @(negedge clk);
      opcode = op; RA = ra; RB = rb; RPC = rpc; IncPC = inc; brn_flag = brn;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      l = 0;
      b = 0;
      while (l < 200) begin
         @(negedge clk);
         l++;
         if (busy) b++;
         if (ignore_at != 0 && l == ignore_at) begin
            start  = 1'b1;
            opcode = 5'b00011;
         end else begin
            start = 1'b0;
         end
         if (done) break;
      end
      start = 1'b0;
   endtask

   initial begin
      clr = 1'b1; start = 1'b0; opcode = '0; RA = '0; RB = '0; RPC = '0;
      IncPC = 1'b0; brn_flag = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_RC", RC, 64'h0);
      check("rst_aluPC", {32'h0, aluPC}, 64'h0);
      check("rst_busy", {63'h0, busy}, 64'h0);
      check("rst_done", {63'h0, done}, 64'h0);
      check("rst_div_zero", {63'h0, div_zero}, 64'h0);
      clr = 1'b0;

      run_op(5'b00011, 32'hFFFFFFFF, 32'h1, 32'h10, 1'b1, 1'b0, 0, lat, bcnt);
      check("add_lat", lat, 1);
      check("add_RC", RC, 64'h0);
      check("add_pc", {32'h0, aluPC}, 64'h11);
      @(negedge clk);
      check("add_done_pulse", {63'h0, done}, 64'h0);

      run_op(5'b01110, 32'hFFFFFFFD, 32'h7, 32'h50, 1'b1, 1'b0, 0, lat, bcnt);
      check("mul_lat", lat, 34);
      check("mul_busy_cycles", bcnt, 34);
      check("mul_RC", RC, 64'hFFFFFFFF_FFFFFFEB);
      check("mul_pc", {32'h0, aluPC}, 64'h51);
      @(negedge clk);
      check("mul_done_pulse", {63'h0, done}, 64'h0);
      check("mul_RC_hold", RC, 64'hFFFFFFFF_FFFFFFEB);

      run_op(5'b01111, 32'hFFFFFFF9, 32'h2, 32'h0, 1'b0, 1'b0, 0, lat, bcnt);
      check("div_lat", lat, 34);
      check("div_RC", RC, 64'hFFFFFFFF_FFFFFFFD);
      check("div_dz", {63'h0, div_zero}, 64'h0);

      run_op(5'b01111, 32'h5, 32'h0, 32'h0, 1'b0, 1'b0, 0, lat, bcnt);
      check("div0_RC", RC, 64'h00000005_FFFFFFFF);
      check("div0_dz", {63'h0, div_zero}, 64'h1);

      run_op(5'b00011, 32'h1, 32'h1, 32'h0, 1'b0, 1'b0, 0, lat, bcnt);
      check("dz_clear", {63'h0, div_zero}, 64'h0);

      run_op(5'b01111, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0, 0, lat, bcnt);
      check("div_ovf_RC", RC, 64'h00000000_80000000);

      run_op(5'b01111, 32'd100, 32'hFFFFFFF9, 32'h0, 1'b0, 1'b0, 0, lat, bcnt);
      check("div_neg_b_RC", RC, 64'h00000002_FFFFFFF2);

      run_op(5'b01111, 32'hFFFFFFF9, 32'h0, 32'h0, 1'b0, 1'b0, 0, lat, bcnt);
      check("div0_neg_RC", RC, 64'hFFFFFFF9_FFFFFFFF);

      run_op(5'b01110, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h0, 1'b0, 1'b0, 0, lat, bcnt);
      check("mul_maxpos", RC, 64'h3FFFFFFF_00000001);

      run_op(5'b01110, 32'h80000000, 32'h80000000, 32'h0, 1'b0, 1'b0, 0, lat, bcnt);
      check("mul_minneg", RC, 64'h40000000_00000000);

      run_op(5'b01110, 32'h2, 32'h3, 32'h0, 1'b0, 1'b0, 5, lat, bcnt);
      check("mul_ignore_lat", lat, 34);
      check("mul_ignore_RC", RC, 64'h6);
      @(negedge clk);
      check("mul_ignore_idle", {63'h0, busy}, 64'h0);

      run_op(5'b01000, 32'h80000001, 32'h4, 32'h0, 1'b0, 1'b0, 0, lat, bcnt);
      check("rol4", RC, 64'h18);
      run_op(5'b01000, 32'h80000001, 32'h24, 32'h0, 1'b0, 1'b0, 0, lat, bcnt);
      check("rol_amt_mask", RC, 64'h18);
      run_op(5'b00111, 32'h80000001, 32'h4, 32'h0, 1'b0, 1'b0, 0, lat, bcnt);
      check("ror4", RC, 64'h18000000);
      run_op(5'b00101, 32'h80000001, 32'h0, 32'h0, 1'b0, 1'b0, 0, lat, bcnt);
      check("shr0", RC, 64'h80000001);
      run_op(5'b00101, 32'h80000001, 32'h4, 32'h0, 1'b0, 1'b0, 0, lat, bcnt);
      check("shr4", RC, 64'h08000000);
      run_op(5'b00110, 32'h80000001, 32'h4, 32'h0, 1'b0, 1'b0, 0, lat, bcnt);
      check("shl4", RC, 64'h10);

      run_op(5'b00100, 32'h5, 32'h7, 32'h0, 1'b0, 1'b0, 0, lat, bcnt);
      check("sub", RC, 64'hFFFFFFFE);
      run_op(5'b10000, 32'h5, 32'h0, 32'h0, 1'b0, 1'b0, 0, lat, bcnt);
      check("neg", RC, 64'hFFFFFFFB);
      run_op(5'b10001, 32'h0, 32'h0F0F0F0F, 32'h0, 1'b0, 1'b0, 0, lat, bcnt);
      check("not", RC, 64'hF0F0F0F0);
      run_op(5'b01001, 32'hF0F0, 32'h0FF0, 32'h0, 1'b0, 1'b0, 0, lat, bcnt);
      check("and", RC, 64'h00F0);
      run_op(5'b01010, 32'hF0F0, 32'h0FF0, 32'h0, 1'b0, 1'b0, 0, lat, bcnt);
      check("or", RC, 64'hFFF0);

      run_op(5'b10010, 32'h100, 32'h4, 32'h20, 1'b1, 1'b1, 0, lat, bcnt);
      check("br_taken_pc", {32'h0, aluPC}, 64'h104);
      check("br_taken_RC", RC, 64'h0);
      run_op(5'b10010, 32'h100, 32'h4, 32'h20, 1'b1, 1'b0, 0, lat, bcnt);
      check("br_not_taken_pc", {32'h0, aluPC}, 64'h21);
      run_op(5'b10011, 32'h200, 32'h8, 32'h20, 1'b1, 1'b0, 0, lat, bcnt);
      check("jr_pc", {32'h0, aluPC}, 64'h208);
      run_op(5'b10100, 32'h40, 32'h2, 32'h30, 1'b0, 1'b0, 0, lat, bcnt);
      check("jal_pc", {32'h0, aluPC}, 64'h42);
      check("jal_RC", RC, 64'h31);
      run_op(5'b11001, 32'h40, 32'h2, 32'h7, 1'b1, 1'b0, 0, lat, bcnt);
      check("nop_RC", RC, 64'h0);
      check("nop_pc", {32'h0, aluPC}, 64'h8);
      run_op(5'b11111, 32'h40, 32'h2, 32'h7, 1'b0, 1'b0, 0, lat, bcnt);
      check("undef_pc", {32'h0, aluPC}, 64'h7);

      run_op(5'b00011, 32'h1, 32'h2, 32'h9, 1'b1, 1'b0, 0, lat, bcnt);
      check("pre_abort_RC", RC, 64'h3);
      @(negedge clk);
      opcode = 5'b01111; RA = 32'd1000; RB = 32'd3; RPC = 32'h0; IncPC = 1'b0;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (9) @(negedge clk);
      clr = 1'b1;
      @(posedge clk);
      #1 clr = 1'b0;
      @(negedge clk);
      check("abort_busy", {63'h0, busy}, 64'h0);
      check("abort_done", {63'h0, done}, 64'h0);
      check("abort_RC", RC, 64'h0);
      check("abort_pc", {32'h0, aluPC}, 64'h0);
      check("abort_dz", {63'h0, div_zero}, 64'h0);
      dcnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done || busy) dcnt++;
      end
      check("abort_no_done", dcnt, 0);

      run_op(5'b00011, 32'h4, 32'h5, 32'h0, 1'b0, 1'b0, 0, lat, bcnt);
      check("post_abort_lat", lat, 1);
      check("post_abort_RC", RC, 64'h9);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
